// File: rtl/mips_pkg.sv
// Shared MIPS32 datapath types and constants.
// Provides register/data widths, the hardwired-zero register number and the
// writeback entry record (destination + result) stored in the writeback FIFO.
package mips_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/mips_wb_fifo.sv
// Circular FIFO of writeback entries for ALU results awaiting the write port.
// Ports:
//   clock, reset_n   rising-edge clock, asynchronous active-low reset
//   push, din        enqueue din at the tail (caller never pushes when full)
//   pop, dout        dequeue the head; dout always shows the current head
//   count            number of valid entries (0..DEPTH)
//   valid, dests     per-slot valid flag and destination, for hazard matching
module mips_wb_fifo
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              push,
    input  logic                              pop,
    input  wb_entry_t                         din,
    output wb_entry_t                         dout,
    output logic [$clog2(DEPTH):0]            count,
    output logic [DEPTH-1:0]                  valid,
    output logic [DEPTH-1:0][REG_W-1:0]       dests
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    wb_entry_t         entries_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q;

    logic do_push, do_pop;

    assign do_push = push && (count_q != CW'(DEPTH));
    assign do_pop  = pop && (count_q != '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clock) begin
        if (do_push) entries_q[wr_ptr_q] <= din;
    end

    assign dout  = entries_q[rd_ptr_q];
    assign count = count_q;

    // A slot is live when its distance from the head is below the count.
    always_comb begin
        logic [PW-1:0] offset;
        valid  = '0;
        dests  = '0;
        offset = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            offset   = PW'(i) - rd_ptr_q;
            valid[i] = ({1'b0, offset} < count_q);
            dests[i] = entries_q[i].dest;
        end
    end

endmodule

// File: rtl/mips_writeback_unit.sv
// Writeback arbiter for the MIPS32 register file write port.
// Loads win over queued ALU results, which win over a same-cycle ALU bypass;
// ALU results that cannot be written immediately wait in a FIFO.
// Ports:
//   clock, reset_n                    clock and asynchronous active-low reset
//   alu_valid/dest/data, alu_ready    ALU result handshake
//   mem_valid/dest/data               load result, always accepted
//   RegWrite, write_reg, write_data   registered register-file write port
//   hazard_reg, hazard_pending        in-flight write query for hazard logic
//   occupancy                         FIFO entry count
module mips_writeback_unit
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     alu_valid,
    input  logic [REG_W-1:0]         alu_dest,
    input  logic [DATA_W-1:0]        alu_data,
    output logic                     alu_ready,
    input  logic                     mem_valid,
    input  logic [REG_W-1:0]         mem_dest,
    input  logic [DATA_W-1:0]        mem_data,
    output logic                     RegWrite,
    output logic [REG_W-1:0]         write_reg,
    output logic [DATA_W-1:0]        write_data,
    input  logic [REG_W-1:0]         hazard_reg,
    output logic                     hazard_pending,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    wb_entry_t                   fifo_din, fifo_dout;
    logic [CW-1:0]               fifo_count;
    logic [DEPTH-1:0]            fifo_valid;
    logic [DEPTH-1:0][REG_W-1:0] fifo_dests;

    logic load_sel, alu_acc, fifo_empty;
    logic fifo_push, fifo_pop, bypass;

    logic              wr_en_d, wr_en_q;
    logic [REG_W-1:0]  wr_reg_d, wr_reg_q;
    logic [DATA_W-1:0] wr_data_d, wr_data_q;

    mips_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .din     (fifo_din),
        .dout    (fifo_dout),
        .count   (fifo_count),
        .valid   (fifo_valid),
        .dests   (fifo_dests)
    );

    // Ready depends only on the registered count; a same-cycle pop does not help.
    assign alu_ready  = (fifo_count != CW'(DEPTH));
    assign fifo_empty = (fifo_count == '0);

    // Writes to r0 are dropped: a load to r0 does not compete for the port,
    // an ALU result to r0 is handshaken but goes nowhere.
    assign load_sel = mem_valid && (mem_dest != REG_ZERO);
    assign alu_acc  = alu_valid && alu_ready && (alu_dest != REG_ZERO);

    assign fifo_pop  = !load_sel && !fifo_empty;
    assign bypass    = alu_acc && !load_sel && fifo_empty;
    assign fifo_push = alu_acc && !bypass;
    assign fifo_din  = '{dest: alu_dest, data: alu_data};

    always_comb begin
        wr_en_d   = 1'b0;
        wr_reg_d  = wr_reg_q;
        wr_data_d = wr_data_q;
        if (load_sel) begin
            wr_en_d   = 1'b1;
            wr_reg_d  = mem_dest;
            wr_data_d = mem_data;
        end else if (fifo_pop) begin
            wr_en_d   = 1'b1;
            wr_reg_d  = fifo_dout.dest;
            wr_data_d = fifo_dout.data;
        end else if (bypass) begin
            wr_en_d   = 1'b1;
            wr_reg_d  = alu_dest;
            wr_data_d = alu_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_en_q   <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_reg_q  <= wr_reg_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign RegWrite   = wr_en_q;
    assign write_reg  = wr_reg_q;
    assign write_data = wr_data_q;
    assign occupancy  = fifo_count;

    always_comb begin
        logic match;
        match = wr_en_q && (wr_reg_q == hazard_reg);
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (fifo_valid[i] && (fifo_dests[i] == hazard_reg)) match = 1'b1;
        end
        hazard_pending = (hazard_reg != REG_ZERO) && match;
    end

endmodule

// File: doc/mips_writeback_unit.md
# mips_writeback_unit

Writeback arbiter and buffer that sits directly upstream of the register file in the MIPS32 datapath. It collects destination/result pairs from the ALU path and the load path, queues ALU results that cannot be written immediately, and issues at most one write per cycle on the register file's write port (RegWrite, write_reg, write_data). It also reports whether a queried register still has a write in flight, for the hazard logic.

## Interface
- DEPTH, 4, ALU-result FIFO entries; power of two, minimum 2
- clock  in  1  rising-edge clock, shared with the register file
- reset_n  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU result offered this cycle
- alu_dest  in  5  ALU destination register
- alu_data  in  32  ALU result
- alu_ready  out  1  ALU result accepted when alu_valid && alu_ready
- mem_valid  in  1  load result present this cycle; always accepted, no backpressure
- mem_dest  in  5  load destination register
- mem_data  in  32  load data
- RegWrite  out  1  register-file write enable, registered
- write_reg  out  5  register-file write address, registered
- write_data  out  32  register-file write data, registered
- hazard_reg  in  5  register number queried by hazard logic
- hazard_pending  out  1  write to hazard_reg is queued or on the output
- occupancy  out  $clog2(DEPTH)+1  current FIFO entry count

## Operation
- Writes with destination 0 are discarded:
  - Load with mem_dest==0: treated as mem_valid=0 for arbitration.
  - ALU result with alu_dest==0: accepted while alu_ready=1, never pushed, never written.
- alu_ready = (occupancy != DEPTH), from registered count only. A pop in the same cycle does not raise it.
- Per-cycle selection, in strict priority:
  1. Load (mem_valid, mem_dest!=0).
  2. FIFO head, which is popped.
  3. Accepted ALU result, bypassed only when the FIFO is empty and no load is selected.
  4. Nothing.
- Any accepted nonzero ALU result that is not bypassed is pushed at the tail the same cycle. Push and pop may coincide.
- ALU results are written in acceptance order. Loads may overtake queued ALU results; the upstream pipeline guarantees no WAW between the two paths.
- Output register: on the edge after selection, RegWrite=1 with the selected dest/data, else RegWrite=0. write_reg and write_data hold their last values when RegWrite=0.
- hazard_pending = (hazard_reg!=0) and (hazard_reg matches any valid FIFO entry, or matches write_reg while RegWrite=1). Combinational from registered state only.
- Sustained loads starve the FIFO; upstream bounds load bursts. No starvation counter.

## Timing
- Reset (async assert, sync release):
  - RegWrite=0, write_reg=0, write_data=0
  - occupancy=0, FIFO pointers=0, alu_ready=1, hazard_pending=0
- Latency, input to RegWrite high:
  - Load: 1 cycle.
  - Bypassed ALU result: 1 cycle.
  - Queued ALU result: 1 cycle after it reaches the head and no load is selected.
- Register file commits on the edge after RegWrite rises, so data reaches the registers 2 edges after the input cycle.
- Pointers wrap modulo DEPTH. Full: occupancy==DEPTH. Empty: occupancy==0.
- Push when full cannot occur, because alu_ready=0. An offered result while full is held upstream.
- Reset mid-burst drops all queued entries and the pending write. No write is issued during or after reset until new input arrives.

## Structure
- Shared package mips_pkg:
  - REG_W=5, DATA_W=32
  - REG_ZERO=5'd0
  - wb_entry_t packed struct {dest, data}
- One sub-module: mips_wb_fifo.
  - Parameterised DEPTH, storing wb_entry_t.
  - Ports: clock, reset_n, push, pop, din, dout, count, and a per-entry valid/dest view for hazard matching.
- Top level holds the arbitration, the output register and the hazard compare.

## Test plan
- Reset, then alu_valid with dest=5, data=0x1234 on an idle unit -> next cycle RegWrite=1, write_reg=5, write_data=0x1234; occupancy stays 0.
- Load dest=3 and ALU dest=4 in the same cycle -> cycle+1 writes r3; r4 is queued (occupancy=1), then written at cycle+2; occupancy returns to 0.
- Hold mem_valid for 6 cycles while offering ALU dests 1..6 -> alu_ready drops after 4 accepts (occupancy=4). ALU writes then follow in order 1,2,3,4 after mem_valid drops, then 5,6 once accepted.
- ALU dest=0 and load dest=0 with data 0xFFFFFFFF -> RegWrite never asserts; occupancy stays 0.
- ALU dest=9 queued behind a load, hazard_reg=9 -> hazard_pending=1 until the cycle after RegWrite with write_reg=9 deasserts; hazard_reg=0 -> always 0.
- Fill the FIFO to 3 entries, assert reset_n=0 mid-cycle -> immediately occupancy=0, RegWrite=0, alu_ready=1; no stale write after release.
